serial_deframer: RTL

- Receive-side stage that consumes the serial bit stream produced by the switch-scanning mux, together with the 3-bit scan index that selected each bit.
- Reassembles the stream into a stable parallel word, so the LEDs show a latched value instead of a flickering demux output.
- Flags frame completion and changes in the word, counts frames, and detects index-sequence errors.
- Sits between the serial link (mux plus counter) and the LED/display logic.

---
 rtl/serial_deframer.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_deframer.sv
// Serial-to-parallel deframer: rebuilds the scanned switch word from
// the muxed bit stream, flags completions, changes and index breaks.
module serial_deframer #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata,
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             changed,
    output logic [7:0]       frame_cnt,
    output logic             seq_err
);

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);
    localparam logic S_SYNC    = 1'b0;
    localparam logic S_COLLECT = 1'b1;

    logic             r_state;
    logic             w_state_nxt;
    logic [IDXW-1:0]  r_expected;
    logic [WIDTH-2:0] r_shift;
    logic             r_first;

    logic             w_hit;
    logic             w_store;
    logic             w_done;
    logic             w_err;
    logic [WIDTH-1:0] w_new_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_SYNC: begin
                if (en && idx == '0) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                // a break on idx 0 restarts a frame, so stay collecting
                if (w_err && idx != '0) w_state_nxt = S_SYNC;
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    always_comb begin
        w_hit      = en && (idx == r_expected);
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_store    = 1'b0;
        w_new_word = {sdata, r_shift};
        if (r_state == S_SYNC) begin
            w_store = en && (idx == '0);
        end else begin
            w_done  = w_hit && (idx == LAST);
            w_err   = en && !w_hit;
            w_store = (w_hit && !w_done) || (w_err && idx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected <= '0;
            r_shift    <= '0;
            r_first    <= 1'b1;
            word       <= '0;
            word_valid <= 1'b0;
            changed    <= 1'b0;
            frame_cnt  <= 8'd0;
            seq_err    <= 1'b0;
        end else begin
            word_valid <= w_done;
            changed    <= w_done && ((w_new_word != word) || r_first);
            if (w_done) begin
                word       <= w_new_word;
                r_first    <= 1'b0;
                frame_cnt  <= frame_cnt + 8'd1;
                r_expected <= '0;
            end else if (w_store) begin
                r_expected <= idx + 1'b1;
            end
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (w_store && idx == IDXW'(i)) r_shift[i] <= sdata;
            end
            if (w_err) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule
